// File: rtl/odd_parity_pkg.sv
// Shared odd-parity link definitions: state encoding and parity convention.
// Used by both the receiver and the transmit-side generator.
package odd_parity_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;

  localparam logic ODD_PARITY = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_BREAK  = ST_BREAK
  } rx_state_e;

  // acc is the XOR of data and parity bits; odd count of ones means acc == 1
  function automatic logic parity_ok(input logic acc);
    return acc == ODD_PARITY;
  endfunction

endpackage

// File: rtl/odd_parity_rx_if.sv
// Serial line in, word/status/error-count out; master drives the line, slave is the receiver.
interface odd_parity_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              din;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output din, err_clr,
    input  data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );

  modport slave (
    input  din, err_clr,
    output data_out, data_valid, parity_err, frame_err, busy, err_cnt
  );
endinterface

// File: rtl/odd_parity_rx.sv
// Odd-parity serial frame receiver: word reported one cycle after the stop bit is sampled.
// No backpressure: the consumer must take each data_valid pulse; frames arrive back-to-back.
module odd_parity_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  odd_parity_rx_if.slave rx
);

  localparam int              BCW      = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);

  rx_state_e         state;
  rx_state_e         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W:0]   sh_ext;
  logic [BCW-1:0]    bit_cnt;
  logic              acc;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_c;

  // right shift with the new bit entering at the MSB; also valid for DATA_W == 1
  assign sh_ext = {rx.din, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (!rx.din) state_nxt = S_DATA;
      end
      S_DATA:   if (bit_cnt == LAST_BIT) state_nxt = S_PARITY;
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = rx.din ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx.din) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      acc     <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          acc     <= 1'b0;
        end
        S_DATA: begin
          shreg   <= sh_ext[DATA_W:1];
          acc     <= acc ^ rx.din;
          bit_cnt <= bit_cnt + BCW'(1);
        end
        S_PARITY: acc <= acc ^ rx.din;
        S_STOP: begin
          data_q  <= shreg;
          valid_q <= 1'b1;
          perr_q  <= ~parity_ok(acc);
          ferr_q  <= ~rx.din;
        end
        default: ;
      endcase
    end
  end

  // clear takes priority over a coincident error increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rx.err_clr) begin
      cnt_q <= '0;
    end else if (valid_q && (perr_q || ferr_q) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = busy_c;
  assign rx.err_cnt    = cnt_q;

endmodule

// File: tb/tb_odd_parity_rx.sv
// Bench for odd_parity_rx: directed frame table, reset/saturation sequences, random frames vs a frame-level model.
module tb_odd_parity_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b1;
  logic clr8 = 1'b0;
  logic clr2 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  odd_parity_rx_if #(.DATA_W(8), .CNT_W(8)) a_if ();
  odd_parity_rx_if #(.DATA_W(8), .CNT_W(2)) b_if ();

  assign a_if.din     = din;
  assign b_if.din     = din;
  assign a_if.err_clr = clr8;
  assign b_if.err_clr = clr2;

  odd_parity_rx #(.DATA_W(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .rx(a_if));
  odd_parity_rx #(.DATA_W(8), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .rx(b_if));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         brk;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t expq[$];
  exp_t e;
  vec_t vecs[6];
  int   m8 = 0;
  int   m2 = 0;
  logic hit_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame-level reference: ones in data plus parity must be odd.
  function automatic logic model_perr(input logic [7:0] d, input logic p);
    return (($countones(d) + int'(p)) % 2) == 0;
  endfunction

  task automatic drive(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int brk, input int gap, input logic [7:0] ed,
                            input logic ep, input logic ef, input logic clr_on_pulse);
    int s_edge;
    exp_t x;
    repeat (gap) drive(1'b1);
    drive(1'b0);
    s_edge = cyc;
    check("busy_after_start", a_if.busy, 1);
    for (int i = 0; i < 8; i++) drive(d[i]);
    drive(p);
    drive(s);
    x.data = ed; x.perr = ep; x.ferr = ef; x.due = s_edge + 10;
    expq.push_back(x);
    if (clr_on_pulse) begin
      clr8 = 1'b1;
      clr2 = 1'b1;
      din  = 1'b1;
      @(posedge clk);
      #1;
      clr8 = 1'b0;
      clr2 = 1'b0;
    end
    if (!s) begin
      check("busy_in_break", a_if.busy, 1);
      for (int i = 0; i < brk; i++) begin
        drive(1'b0);
        check("busy_hold_break", a_if.busy, 1);
      end
      drive(1'b1);
      check("busy_after_break", a_if.busy, 0);
    end else if (!clr_on_pulse) begin
      check("busy_after_stop", a_if.busy, 0);
    end
  endtask

  // Pulse scoreboard and error-count model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m8 = 0;
      m2 = 0;
      check("rst_valid", a_if.data_valid, 0);
    end else begin
      check("err_cnt8", a_if.err_cnt, m8);
      check("err_cnt2", b_if.err_cnt, m2);
      hit_err = 1'b0;
      if (a_if.data_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = expq.pop_front();
          check("data_out", a_if.data_out, e.data);
          check("parity_err", a_if.parity_err, e.perr);
          check("frame_err", a_if.frame_err, e.ferr);
          check("pulse_cycle", cyc, e.due);
          check("b_valid", b_if.data_valid, 1);
          check("b_data_out", b_if.data_out, e.data);
          hit_err = e.perr | e.ferr;
        end
      end else if (expq.size() > 0 && expq[0].due < cyc) begin
        check("missing_pulse", cyc, expq[0].due);
        void'(expq.pop_front());
      end
      if (clr8) m8 = 0;
      else if (hit_err && m8 != 255) m8 = m8 + 1;
      if (clr2) m2 = 0;
      else if (hit_err && m2 != 3) m2 = m2 + 1;
    end
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0, 2, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 0, 1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 5, 1, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 0, 2, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 0, 0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h03, 1'b0, 1'b0, 1, 1, 8'h03, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", a_if.data_out, 0);
    check("rst_parity_err", a_if.parity_err, 0);
    check("rst_frame_err", a_if.frame_err, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_err_cnt", a_if.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].brk, vecs[i].gap,
                 vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
    repeat (3) drive(1'b1);
    check("cnt_after_table", a_if.err_cnt, 3);

    // abort a frame with reset after 4 data bits
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(i[0]);
    din   = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", a_if.busy, 0);
    check("abort_data_out", a_if.data_out, 0);
    check("abort_err_cnt", a_if.err_cnt, 0);
    check("abort_valid", a_if.data_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1, 1'b1, 0, 2, 8'h3C, 1'b0, 1'b0, 1'b0);

    // saturation of the 2-bit counter, then clear on a pulse cycle
    for (int i = 0; i < 5; i++)
      send_frame(8'h5A, 1'b0, 1'b1, 0, 1, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b1);
    check("sat_cnt2", b_if.err_cnt, 3);
    check("sat_cnt8", a_if.err_cnt, 5);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1, 8'h5A, 1'b1, 1'b0, 1'b1);
    check("clr_cnt2", b_if.err_cnt, 0);
    check("clr_cnt8", a_if.err_cnt, 0);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) != 0) ? ~^d : ^d;
      s = ($urandom_range(0, 9) != 0);
      send_frame(d, p, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 d, model_perr(d, p), ~s, 1'b0);
    end

    repeat (20) drive(1'b1);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
